// File: rtl/vc_arbiter.sv
// Round-robin drain of four upstream VC FIFOs into four downstream FIFOs,
// routed by word[9:8], with global almost_full backpressure.
module vc_arbiter #(
   parameter int DATA_W = 10,
   parameter int NUM_VC = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NUM_VC-1:0] empty_in,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic [NUM_VC-1:0] almost_full_in,
   output logic [NUM_VC-1:0] pop,
   output logic [NUM_VC-1:0] push,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        grant_vc,
   output logic [1:0]        fsm_state,
   output logic              idle
);

   // state  | meaning
   // IDLE   | no VC requesting
   // ACTIVE | requests present, popping one word per cycle
   // STALL  | requests present, held off by downstream almost_full
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      STALL  = 2'b10
   } state_t;

   state_t            state, state_nxt;
   logic [NUM_VC-1:0] req;
   logic              blocked;
   logic              gnt_found;
   logic              grant;
   logic [1:0]        gnt_idx;
   logic [1:0]        cand;
   logic [1:0]        sel1;
   logic              v1;
   logic [DATA_W-1:0] word;

   assign req     = ~empty_in;
   assign blocked = |almost_full_in;
   assign grant   = gnt_found && !blocked;

   // search starts one past the last grant so the previous winner goes last
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = grant_vc;
      cand      = grant_vc;
      for (int i = 1; i <= NUM_VC; i++) begin
         cand = grant_vc + 2'(i);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = '0;
      if (req == '0)
         state_nxt = IDLE;
      else if (blocked)
         state_nxt = STALL;
      else
         state_nxt = ACTIVE;
      // gated by reset_L so pop drops the moment reset asserts
      if (reset_L && grant)
         pop[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         v1       <= 1'b0;
         sel1     <= 2'd0;
         grant_vc <= 2'd3;
      end else begin
         v1 <= grant;
         if (grant) begin
            sel1     <= gnt_idx;
            grant_vc <= gnt_idx;
         end
      end
   end

   always_comb begin
      case (sel1)
         2'd0:    word = data_in0;
         2'd1:    word = data_in1;
         2'd2:    word = data_in2;
         default: word = data_in3;
      endcase
   end

   // an all-zero word is captured but never pushed; downstream ignores it
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         push     <= '0;
         data_out <= '0;
      end else if (v1) begin
         data_out <= word;
         if (word == '0)
            push <= '0;
         else
            push <= NUM_VC'(1) << word[DATA_W-1 -: 2];
      end else begin
         push <= '0;
      end
   end

   assign fsm_state = state;
   assign idle      = (state == IDLE) && !v1 && (push == '0);

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Downstream consumer of the four per-virtual-channel 10-bit FIFOs (VC0..VC3) in the transaction layer.
- Pops words from the non-empty upstream FIFOs in round-robin order.
- Routes each word, by its destination field, to one of four downstream FIFOs.
- Applies global backpressure from the downstream almost_full flags and reports idle/stall status to the control state machine.

Parameters:
DATA_W, 10, word width; bits [9:8] are the destination select.
NUM_VC, 4, number of upstream FIFOs and of downstream FIFOs (fixed at 4; 2-bit indices).

Ports:
clk  input  1  single clock; all state updates on posedge
reset_L  input  1  asynchronous, active-low reset
empty_in  input  4  empty flags of upstream FIFOs VC3..VC0
data_in0  input  10  data_out of upstream FIFO VC0 (valid the cycle after its pop)
data_in1  input  10  same, VC1
data_in2  input  10  same, VC2
data_in3  input  10  same, VC3
almost_full_in  input  4  almost_full flags of downstream FIFOs D3..D0
pop  output  4  one-hot pop to upstream FIFOs (combinational from registered state and inputs)
push  output  4  one-hot push to downstream FIFOs (registered)
data_out  output  10  word for downstream FIFOs (registered, aligned with push)
grant_vc  output  2  index of the last VC granted (registered)
fsm_state  output  2  arbiter state: 00 IDLE, 01 ACTIVE, 10 STALL
idle  output  1  high when no requests and no words in flight

Behaviour:
- Reset (reset_L low, async):
  - pop=0 immediately; push=0, data_out=0, grant_vc=3 (so VC0 is first), fsm_state=IDLE, idle=1.
  - Pipeline valid bits cleared; in-flight words are discarded.
- Stage 0, grant (cycle N):
  - req = ~empty_in. Blocked when any almost_full_in bit is 1.
  - If req!=0 and not blocked: select the first requesting VC searching grant_vc+1, +2, +3, +4 (mod 4); assert pop[k]=1 that cycle.
  - Register sel1<=k, v1<=1, grant_vc<=k. Otherwise pop=0 and v1<=0.
- Stage 1, capture (cycle N+1):
  - The upstream FIFO presents the word on data_in[sel1].
  - If v1: data_out<=word; push<=onehot(word[9:8]). If word==10'b0: push<=0 (the null word is dropped, matching downstream FIFOs that ignore zero data).
  - Otherwise push<=0; data_out holds its last value.
- Latency: pop to push is 2 cycles. Throughput: 1 word/cycle sustained, including back-to-back pops from the same VC.
- Backpressure:
  - Pop is gated combinationally by almost_full_in in the same cycle.
  - At most 2 words are in flight when a stall begins; both still complete their push.
  - Downstream almost_full thresholds are configured to leave at least 3 free entries.
- Round-robin:
  - grant_vc updates only on a grant.
  - A single requesting VC is granted every cycle.
  - With all four requesting, the order is VC0,1,2,3,0...
- FSM (registered, next-state from the current cycle's inputs):
  - IDLE: req==0. ACTIVE: req!=0 and not blocked. STALL: req!=0 and blocked.
  - Any state may move to any state in one cycle.
  - idle = (fsm_state==IDLE) and v1==0 and push==0.
- A VC whose empty_in rises in the same cycle it would be granted is not popped (the grant is evaluated on current empty_in).
- Reset asserted mid-transfer: pop drops in the same cycle, and no push is produced for words already popped upstream. The upstream FIFO is reset alongside, so the lost word is accepted behaviour.
- Data bits [7:0] pass through unmodified.

Test Plan:
1. Reset release, all empty_in=4'hF -> pop=0, push=0, fsm_state=00, idle=1, grant_vc=3 for 10 cycles.
2. Only VC2 non-empty with 3 words 0x005,0x105,0x305 -> pop=0100 for 3 consecutive cycles; 2 cycles later push=0001,0010,1000 with data_out=0x005,0x105,0x305; fsm_state returns to IDLE.
3. All VCs non-empty, no backpressure -> pop sequence 0001,0010,0100,1000,0001; grant_vc 0,1,2,3,0.
4. Streaming from VC0; raise almost_full_in=0010 on cycle M -> pop=0 from M, fsm_state=STALL from M+1, exactly 2 more pushes; deassert -> pops resume next cycle at the next VC in order.
5. VC1 holds the word 0x000 -> pop asserted, no push 2 cycles later, arbitration continues.
6. Assert reset_L=0 while 2 words are in flight -> pop=0 and push=0 immediately; after release no push occurs, idle=1.
